// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: expands one register read/write request into the byte-level
// command sequence for an I2C_controller and reports read data plus completion status.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | ready for a request; fields latched on accept
// S_ISSUE     | present cmd/dat for the current step, one-cycle in_flag strobe
// S_WAIT_BUSY | wait for the controller to raise busy (timeout guarded)
// S_WAIT_DONE | wait for busy to fall, collect ack/read data (timeout guarded)
// S_NEXT      | advance step, or divert to STOP on NACK, or finish
// S_RESP      | one-cycle rsp_valid pulse
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       i2c_in_flag,
  output logic [3:0] i2c_in_cmd,
  output logic [7:0] i2c_in_dat,
  input  logic [7:0] i2c_out_dat,
  input  logic       i2c_out_flag,
  input  logic       i2c_busy
);

  localparam logic [3:0] CMD_START     = 4'd1;
  localparam logic [3:0] CMD_WRITE     = 4'd2;
  localparam logic [3:0] CMD_READ      = 4'd3;
  localparam logic [3:0] CMD_RECV_ACK  = 4'd4;
  localparam logic [3:0] CMD_STOP      = 4'd6;
  localparam logic [3:0] CMD_SEND_NACK = 4'd7;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [11:0] TMO_LIMIT = 12'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_NEXT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  regaddr_q, regaddr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [3:0]  cur_cmd;
  logic [7:0]  cur_dat;
  logic [3:0]  last_step;
  logic        cmd_active;

  // STOP is the final step of both sequences, so a NACK jumps straight to it
  assign last_step = rw_q ? 4'd10 : 4'd7;

  // Command/byte table for the current step of the latched request
  always_comb begin
    cur_cmd = CMD_STOP;
    cur_dat = 8'h00;
    if (rw_q) begin
      case (step_q)
        4'd0:    cur_cmd = CMD_START;
        4'd1:    begin cur_cmd = CMD_WRITE; cur_dat = {dev_q, 1'b0}; end
        4'd2:    cur_cmd = CMD_RECV_ACK;
        4'd3:    begin cur_cmd = CMD_WRITE; cur_dat = regaddr_q; end
        4'd4:    cur_cmd = CMD_RECV_ACK;
        4'd5:    cur_cmd = CMD_START;
        4'd6:    begin cur_cmd = CMD_WRITE; cur_dat = {dev_q, 1'b1}; end
        4'd7:    cur_cmd = CMD_RECV_ACK;
        4'd8:    cur_cmd = CMD_READ;
        4'd9:    cur_cmd = CMD_SEND_NACK;
        default: cur_cmd = CMD_STOP;
      endcase
    end else begin
      case (step_q)
        4'd0:    cur_cmd = CMD_START;
        4'd1:    begin cur_cmd = CMD_WRITE; cur_dat = {dev_q, 1'b0}; end
        4'd2:    cur_cmd = CMD_RECV_ACK;
        4'd3:    begin cur_cmd = CMD_WRITE; cur_dat = regaddr_q; end
        4'd4:    cur_cmd = CMD_RECV_ACK;
        4'd5:    begin cur_cmd = CMD_WRITE; cur_dat = wdata_q; end
        4'd6:    cur_cmd = CMD_RECV_ACK;
        default: cur_cmd = CMD_STOP;
      endcase
    end
  end

  // State and datapath registers; reset abandons any bus activity in flight
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= 4'd0;
      cnt_q     <= 12'd0;
      err_q     <= ERR_OK;
      rdata_q   <= 8'h00;
      ack_q     <= 1'b0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      regaddr_q <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      regaddr_q <= regaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next-state logic: step sequencing, ack/read capture, timeout supervision
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    ack_d     = ack_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    regaddr_d = regaddr_q;
    wdata_d   = wdata_q;

    // Result strobe may arrive any time the command is outstanding, including the busy-fall cycle
    if ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) && i2c_out_flag) begin
      if (cur_cmd == CMD_RECV_ACK && !i2c_out_dat[0]) ack_d = 1'b1;
      if (cur_cmd == CMD_READ) rdata_d = i2c_out_dat;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d      = req_rw;
          dev_d     = req_dev;
          regaddr_d = req_reg;
          wdata_d   = req_wdata;
          step_d    = 4'd0;
          err_d     = ERR_OK;
          rdata_d   = 8'h00;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 12'd0;
        ack_d   = 1'b0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i2c_busy) begin
          cnt_d   = 12'd0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q >= TMO_LIMIT) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = 8'h00;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!i2c_busy) begin
          state_d = S_NEXT;
        end else if (cnt_q >= TMO_LIMIT) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = 8'h00;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_NEXT: begin
        if (cur_cmd == CMD_RECV_ACK && !ack_q) begin
          err_d   = ERR_NACK;
          rdata_d = 8'h00;
          step_d  = last_step;
          state_d = S_ISSUE;
        end else if (step_q == last_step) begin
          state_d = S_RESP;
        end else begin
          step_d  = step_q + 4'd1;
          state_d = S_ISSUE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // cmd/dat stay on the bus from the strobe until the controller finishes
  assign cmd_active  = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
  assign i2c_in_flag = (state_q == S_ISSUE);
  assign i2c_in_cmd  = cmd_active ? cur_cmd : 4'd0;
  assign i2c_in_dat  = cmd_active ? cur_dat : 8'h00;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a small I2C_controller responder model.
module tb_i2c_reg_sequencer;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       i2c_in_flag;
  logic [3:0] i2c_in_cmd;
  logic [7:0] i2c_in_dat;
  logic [7:0] i2c_out_dat = 8'h00;
  logic       i2c_out_flag = 1'b0;
  logic       i2c_busy = 1'b0;

  i2c_reg_sequencer #(.TIMEOUT_CYC(15)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_dev      (req_dev),
    .req_reg      (req_reg),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .i2c_in_flag  (i2c_in_flag),
    .i2c_in_cmd   (i2c_in_cmd),
    .i2c_in_dat   (i2c_in_dat),
    .i2c_out_dat  (i2c_out_dat),
    .i2c_out_flag (i2c_out_flag),
    .i2c_busy     (i2c_busy)
  );

  always #5 sys_clk = ~sys_clk;

  localparam logic [3:0] EXP_W_CMD [8]  = '{4'd1, 4'd2, 4'd4, 4'd2, 4'd4, 4'd2, 4'd4, 4'd6};
  localparam logic [7:0] EXP_W_DAT [8]  = '{8'h00, 8'h90, 8'h00, 8'h01, 8'h00, 8'hA5, 8'h00, 8'h00};
  localparam logic [3:0] EXP_R_CMD [11] = '{4'd1, 4'd2, 4'd4, 4'd2, 4'd4, 4'd1, 4'd2, 4'd4, 4'd3, 4'd7, 4'd6};
  localparam logic [7:0] EXP_R_DAT [11] = '{8'h00, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h91, 8'h00, 8'h00, 8'h00, 8'h00};

  int n_vec = 0;
  int n_err = 0;

  // Controller model knobs (written only by the stimulus block)
  logic       model_hang = 1'b0;
  int         nack_at = -1;
  logic [7:0] read_val = 8'h00;

  // Controller model state
  int         cyc = 0;
  int         rack_total = 0;
  int         m_left = 0;
  logic [3:0] m_cmd = 4'd0;
  logic       m_nack = 1'b0;

  // Monitor state
  logic [3:0] log_cmd [$];
  logic [7:0] log_dat [$];
  int         log_cyc [$];
  int         acc_cyc [$];
  int         rsp_cyc [$];
  int         acc_cnt = 0;
  int         rsp_cnt = 0;
  int         flag_viol = 0;
  logic       prev_flag = 1'b0;
  logic [7:0] last_rdata = 8'h00;
  logic [1:0] last_err = 2'b00;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Responder: busy for 3 cycles per command; result strobe on the busy-fall cycle
  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      i2c_busy     <= 1'b0;
      i2c_out_flag <= 1'b0;
      i2c_out_dat  <= 8'h00;
      m_left       <= 0;
    end else begin
      i2c_out_flag <= 1'b0;
      if (i2c_in_flag && !model_hang) begin
        i2c_busy <= 1'b1;
        m_left   <= 3;
        m_cmd    <= i2c_in_cmd;
        if (i2c_in_cmd == 4'd4) begin
          m_nack     <= (rack_total == nack_at);
          rack_total <= rack_total + 1;
        end
      end else if (m_left == 1) begin
        i2c_busy <= 1'b0;
        m_left   <= 0;
        if (m_cmd == 4'd4) begin
          i2c_out_flag <= 1'b1;
          i2c_out_dat  <= {7'd0, m_nack};
        end else if (m_cmd == 4'd3) begin
          i2c_out_flag <= 1'b1;
          i2c_out_dat  <= read_val;
        end
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end
    end
  end

  // Observe commands, accepts and responses mid-cycle
  always @(negedge sys_clk) begin
    if (i2c_in_flag) begin
      log_cmd.push_back(i2c_in_cmd);
      log_dat.push_back(i2c_in_dat);
      log_cyc.push_back(cyc);
      if (prev_flag) flag_viol <= flag_viol + 1;
    end
    prev_flag <= i2c_in_flag;
    if (req_valid && req_ready && !rst) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc.push_back(cyc);
    end
    if (rsp_valid) begin
      rsp_cnt    <= rsp_cnt + 1;
      rsp_cyc.push_back(cyc);
      last_rdata <= rsp_rdata;
      last_err   <= rsp_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lcmd(input int i);
    return (i < log_cmd.size()) ? log_cmd[i] : 4'hF;
  endfunction

  function automatic logic [7:0] ldat(input int i);
    return (i < log_dat.size()) ? log_dat[i] : 8'hEE;
  endfunction

  task automatic wait_rsp(input int r0);
    for (int i = 0; i < 2000; i++) begin
      if (rsp_cnt > r0) break;
      @(posedge sys_clk); #1;
    end
    chk("response_seen", 32'(rsp_cnt > r0), 32'd1);
  endtask

  task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    int a0;
    int r0;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    @(posedge sys_clk); #1;
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = ra;
    req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge sys_clk); #1;
      if (acc_cnt > a0) break;
    end
    req_valid = 1'b0;
    chk("accepted", 32'(acc_cnt > a0), 32'd1);
    wait_rsp(r0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lb;
    int r0;
    int a0;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_dev   = 7'd0;
    req_reg   = 8'h00;
    req_wdata = 8'h00;

    // Reset values
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_in_flag",   32'(i2c_in_flag), 32'd0);
    chk("rst_in_cmd",    32'(i2c_in_cmd),  32'd0);
    chk("rst_in_dat",    32'(i2c_in_dat),  32'h00);
    rst = 1'b0;

    // Write dev=0x48 reg=0x01 data=0xA5, all ACKed
    lb = log_cmd.size();
    send(1'b0, 7'h48, 8'h01, 8'hA5);
    chk("wr_ncmds", 32'(log_cmd.size() - lb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wr_cmd%0d", i), 32'(lcmd(lb + i)), 32'(EXP_W_CMD[i]));
      chk($sformatf("wr_dat%0d", i), 32'(ldat(lb + i)), 32'(EXP_W_DAT[i]));
    end
    chk("wr_err",   32'(last_err),   32'd0);
    chk("wr_rdata", 32'(last_rdata), 32'h00);

    // Read dev=0x48 reg=0x00, controller returns 0x3C
    read_val = 8'h3C;
    lb = log_cmd.size();
    send(1'b1, 7'h48, 8'h00, 8'hFF);
    chk("rd_ncmds", 32'(log_cmd.size() - lb), 32'd11);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("rd_cmd%0d", i), 32'(lcmd(lb + i)), 32'(EXP_R_CMD[i]));
      chk($sformatf("rd_dat%0d", i), 32'(ldat(lb + i)), 32'(EXP_R_DAT[i]));
    end
    chk("rd_err",   32'(last_err),   32'd0);
    chk("rd_rdata", 32'(last_rdata), 32'h3C);

    // Read where the address byte is NACKed: START, WRITE, RECV_ACK, then STOP
    nack_at = rack_total;
    lb = log_cmd.size();
    send(1'b1, 7'h48, 8'h00, 8'h00);
    nack_at = -1;
    chk("nack_ncmds",  32'(log_cmd.size() - lb), 32'd4);
    chk("nack_cmd2",   32'(lcmd(lb + 2)), 32'd4);
    chk("nack_cmd3",   32'(lcmd(lb + 3)), 32'd6);
    chk("nack_err",    32'(last_err),   32'd1);
    chk("nack_rdata",  32'(last_rdata), 32'h00);

    // Controller never raises busy after START
    model_hang = 1'b1;
    lb = log_cmd.size();
    r0 = rsp_cnt;
    send(1'b0, 7'h22, 8'h10, 8'h33);
    model_hang = 1'b0;
    chk("tmo_ncmds", 32'(log_cmd.size() - lb), 32'd1);
    chk("tmo_cmd0",  32'(lcmd(lb)), 32'd1);
    chk("tmo_latency", 32'((rsp_cyc.size() > r0 && log_cyc.size() > lb) ? rsp_cyc[r0] - log_cyc[lb] : -1), 32'd17);
    chk("tmo_err",   32'(last_err),   32'd2);
    chk("tmo_rdata", 32'(last_rdata), 32'h00);

    // Reset during WAIT_DONE of the first WRITE command
    lb = log_cmd.size();
    a0 = acc_cnt;
    @(posedge sys_clk); #1;
    req_rw    = 1'b0;
    req_dev   = 7'h48;
    req_reg   = 8'h01;
    req_wdata = 8'hA5;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge sys_clk); #1;
      if (acc_cnt > a0) req_valid = 1'b0;
      if (log_cmd.size() >= lb + 2) break;
    end
    req_valid = 1'b0;
    chk("mid_wr_issued", 32'(lcmd(lb + 1)), 32'd2);
    @(posedge sys_clk); #1;
    chk("mid_cmd_held",  32'(i2c_in_cmd),  32'd2);
    chk("mid_dat_held",  32'(i2c_in_dat),  32'h90);
    chk("mid_not_ready", 32'(req_ready),   32'd0);
    chk("mid_flag_low",  32'(i2c_in_flag), 32'd0);
    rst = 1'b1;
    #1;
    chk("mrst_req_ready", 32'(req_ready),   32'd1);
    chk("mrst_rsp_valid", 32'(rsp_valid),   32'd0);
    chk("mrst_in_flag",   32'(i2c_in_flag), 32'd0);
    chk("mrst_in_cmd",    32'(i2c_in_cmd),  32'd0);
    chk("mrst_in_dat",    32'(i2c_in_dat),  32'h00);
    chk("mrst_rsp_err",   32'(rsp_err),     32'd0);
    chk("mrst_rsp_rdata", 32'(rsp_rdata),   32'h00);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    lb = log_cmd.size();
    send(1'b0, 7'h48, 8'h01, 8'hA5);
    chk("post_rst_ncmds", 32'(log_cmd.size() - lb), 32'd8);
    chk("post_rst_err",   32'(last_err), 32'd0);

    // Back-to-back with req_valid held; fields change right after the first accept
    lb = log_cmd.size();
    a0 = acc_cnt;
    r0 = rsp_cnt;
    @(posedge sys_clk); #1;
    req_rw    = 1'b0;
    req_dev   = 7'h48;
    req_reg   = 8'h02;
    req_wdata = 8'h11;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge sys_clk); #1;
      if (acc_cnt > a0) break;
    end
    req_dev   = 7'h50;
    req_reg   = 8'h03;
    req_wdata = 8'h22;
    for (int i = 0; i < 500; i++) begin
      if (acc_cnt > a0 + 1) break;
      @(posedge sys_clk); #1;
    end
    req_valid = 1'b0;
    chk("b2b_two_accepts", 32'(acc_cnt - a0), 32'd2);
    wait_rsp(r0 + 1);
    chk("b2b_gap", 32'((acc_cyc.size() > a0 + 1 && rsp_cyc.size() > r0) ? acc_cyc[a0 + 1] - rsp_cyc[r0] : -1), 32'd1);
    chk("b2b_a_dev",  32'(ldat(lb + 1)), 32'h90);
    chk("b2b_a_reg",  32'(ldat(lb + 3)), 32'h02);
    chk("b2b_a_wd",   32'(ldat(lb + 5)), 32'h11);
    chk("b2b_b_dev",  32'(ldat(lb + 9)), 32'hA0);
    chk("b2b_b_reg",  32'(ldat(lb + 11)), 32'h03);
    chk("b2b_b_wd",   32'(ldat(lb + 13)), 32'h22);
    chk("b2b_err",    32'(last_err), 32'd0);

    @(posedge sys_clk); #1;
    chk("flag_single_cycle", 32'(flag_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
